digit_serial_adder: RTL and testbench
=====================================

DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WIDTH  16  operand/result width in bits; WIDTH >= 2
  DIGIT  4  bits added per clock cycle; WIDTH SHALL be an integer multiple of DIGIT
REQ-002 NDIG SHALL denote WIDTH/DIGIT; parameter values violating REQ-001 SHALL fail elaboration.
REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-low. Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  synchronous active-low reset
  in_valid  in  1  operands valid
  in_ready  out  1  block can accept operands
  x  in  WIDTH  operand A
  y  in  WIDTH  operand B
  cin  in  1  carry-in (add) / borrow-in (subtract)
  sub  in  1  0 = add, 1 = subtract
  out_valid  out  1  result valid
  out_ready  in  1  consumer accepts result
  s  out  WIDTH  result
  cout  out  1  carry-out (add) / not-borrow (subtract)
  ovf  out  1  two's-complement signed overflow

Function
REQ-004 FSM states SHALL be IDLE, CALC and DONE; in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-005 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1: capture x, y, cin and sub; clear the digit counter; go to CALC.
REQ-006 In IDLE with in_valid=0, the block SHALL stay in IDLE and leave all outputs unchanged.
REQ-007 Effective operand B SHALL be y when sub=0 and ~y when sub=1.
REQ-008 Effective carry-in SHALL be cin when sub=0 and ~cin when sub=1.
REQ-009 Result SHALL be x + y + cin mod 2^WIDTH when sub=0, and x - y - cin mod 2^WIDTH when sub=1.
REQ-010 Each CALC cycle SHALL add one DIGIT-bit slice, least significant first, with captured x, effective B and the carry register.
  - The slice sum SHALL be written into the matching slice of s.
  - The slice carry-out SHALL be registered for the next slice.
REQ-011 The first slice SHALL use the effective carry-in as its carry.
REQ-012 After slice NDIG-1, the FSM SHALL go to DONE.
  - cout SHALL equal the final carry.
  - ovf SHALL be (x[MSB] == effB[MSB]) && (s[MSB] != x[MSB]).
REQ-013 Latency: out_valid SHALL rise on the NDIG-th rising edge after the accepting edge.
  - With DIGIT = WIDTH, latency SHALL be 1.
REQ-014 In DONE, s, cout, ovf and out_valid SHALL hold stable until an edge with out_ready=1.
  - On that edge the FSM SHALL go to IDLE, and in_ready SHALL read 1 in the following cycle.
REQ-015 Changes to x, y, cin or sub after acceptance SHALL NOT affect the current result.
REQ-016 in_valid asserted during CALC or DONE SHALL be ignored; no operand capture SHALL occur.
REQ-017 After the output handshake, s, cout and ovf SHALL retain the last result until the next CALC overwrites them.
  - s SHALL be observed only when out_valid=1.
REQ-018 Throughput SHALL be at most one operation per NDIG+1 cycles; operations SHALL NOT overlap.

Reset
REQ-019 With rst_n=0 at a rising edge, the following SHALL hold after that edge:
  - state IDLE, in_ready=1, out_valid=0
  - s=0, cout=0, ovf=0
  - carry register and digit counter cleared
REQ-020 Reset SHALL take priority over every other event, including mid-CALC and in DONE; any in-flight result SHALL be discarded and never presented.

Verification
REQ-021 The bench SHALL cover the following directed scenarios, with WIDTH=16 and DIGIT=4 unless stated:
  - add: x=0x007A, y=0x009A, cin=0, sub=0 -> s=0x0114, cout=0, ovf=0; out_valid exactly 4 edges after accept.
  - wrap: x=0xFFFF, y=0x0001, cin=0 -> s=0x0000, cout=1, ovf=0; then x=0x7FFF, y=0x0001 -> s=0x8000, cout=0, ovf=1.
  - subtract: x=0x0005, y=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0, ovf=0.
  - subtract with borrow: x=0x0010, y=0x0001, cin=1, sub=1 -> s=0x000E, cout=1.
  - backpressure: hold out_ready=0 for 3 cycles in DONE -> outputs stable; with in_valid=1 and new x throughout, no capture occurs; in_ready returns 1 the cycle after the handshake.
  - reset mid-CALC: rst_n=0 after the 2nd slice -> IDLE, out_valid never asserted, s=0.
  - parameter sweep: DIGIT in {1, 4, 16} with random operands -> s/cout/ovf match the reference model, latency = NDIG.

Source files
------------

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: adds DIGIT bits per cycle, LSB slice first,
// with a valid/ready handshake on both the operand and result sides.
module digit_serial_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_err
        $error("digit_serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [DIGIT-1:0] xs;
    logic [DIGIT-1:0] bs;
    logic [DIGIT:0]   sum;
    logic             last;

    // Select the active slice with constant part-selects to keep indexing static.
    always_comb begin
        xs = '0;
        bs = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (cnt_q == CW'(i)) begin
                xs = x_q[i*DIGIT +: DIGIT];
                bs = b_q[i*DIGIT +: DIGIT];
            end
        end
        sum  = {1'b0, xs} + {1'b0, bs} + {{DIGIT{1'b0}}, carry_q};
        last = (cnt_q == CW'(NDIG - 1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        x_d     = x_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is x + ~y + ~cin, so the borrow-in is inverted too.
                    x_d     = x;
                    b_d     = sub ? ~y : y;
                    carry_d = cin ^ sub;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                for (int i = 0; i < NDIG; i++) begin
                    if (cnt_q == CW'(i)) begin
                        s_d[i*DIGIT +: DIGIT] = sum[DIGIT-1:0];
                    end
                end
                carry_d = sum[DIGIT];
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    cnt_d   = '0;
                    cout_d  = sum[DIGIT];
                    ovf_d   = (x_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum[DIGIT-1] != x_q[WIDTH-1]);
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            x_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            x_q     <= x_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign s         = s_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder: three instances cover DIGIT = 4, 1
// and 16 at WIDTH = 16; index 0 (DIGIT = 4) carries the directed scenarios.
module tb_digit_serial_adder;

    localparam int W = 16;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [15:0] x         [3];
    logic [15:0] y         [3];
    logic        cin       [3];
    logic        sub       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [15:0] s         [3];
    logic        cout      [3];
    logic        ovf       [3];

    int checks;
    int failures;
    int ndig [3];

    digit_serial_adder #(.WIDTH(W), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .x(x[0]), .y(y[0]), .cin(cin[0]), .sub(sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .s(s[0]), .cout(cout[0]), .ovf(ovf[0])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .x(x[1]), .y(y[1]), .cin(cin[1]), .sub(sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .s(s[1]), .cout(cout[1]), .ovf(ovf[1])
    );

    digit_serial_adder #(.WIDTH(W), .DIGIT(16)) u_d16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .x(x[2]), .y(y[2]), .cin(cin[2]), .sub(sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .s(s[2]), .cout(cout[2]), .ovf(ovf[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive operands at a falling edge; the next rising edge accepts them.
    task automatic start_op(input int k, input logic [15:0] a,
                            input logic [15:0] b, input logic ci,
                            input logic sb);
        @(negedge clk);
        in_valid[k] = 1'b1;
        x[k]        = a;
        y[k]        = b;
        cin[k]      = ci;
        sub[k]      = sb;
        @(negedge clk);
        in_valid[k] = 1'b0;
        // Scramble operands after acceptance; the result must not change.
        x[k]   = 16'($urandom);
        y[k]   = 16'($urandom);
        cin[k] = 1'($urandom);
        sub[k] = 1'($urandom);
    endtask

    // Count rising edges after the accepting edge until out_valid is seen.
    task automatic wait_done(input int k, output int lat);
        lat = 0;
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid[k]) begin
            failures++;
            $display("FAIL timeout k=%0d got=out_valid0 exp=out_valid1", k);
        end
    endtask

    task automatic handshake(input int k);
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic run_op(input int k, input logic [15:0] a,
                          input logic [15:0] b, input logic ci,
                          input logic sb, output logic [15:0] rs,
                          output logic rc, output logic ro, output int lat);
        start_op(k, a, b, ci, sb);
        wait_done(k, lat);
        rs = s[k];
        rc = cout[k];
        ro = ovf[k];
        handshake(k);
    endtask

    task automatic ref_model(input logic [15:0] a, input logic [15:0] b,
                             input logic ci, input logic sb,
                             output logic [15:0] rs, output logic rc,
                             output logic ro);
        logic [16:0] full;
        logic [15:0] eb;
        if (sb) full = {1'b0, a} - {1'b0, b} - {16'd0, ci};
        else    full = {1'b0, a} + {1'b0, b} + {16'd0, ci};
        rs = full[15:0];
        // As not-borrow, cout is the inverse of the subtraction borrow.
        rc = sb ? ~full[16] : full[16];
        eb = sb ? ~b : b;
        ro = (a[15] == eb[15]) && (rs[15] != a[15]);
    endtask

    logic [15:0] rs, es;
    logic        rc, ro, ec, eo;
    logic [15:0] ta, tb;
    logic        tc, tsb;
    int          lat;
    bit          seen;

    initial begin
        checks   = 0;
        failures = 0;
        ndig[0]  = 4;
        ndig[1]  = 16;
        ndig[2]  = 1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            x[k]   = '0;
            y[k]   = '0;
            cin[k] = 1'b0;
            sub[k] = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_in_ready", 32'(in_ready[0]), 32'd1);
        check("rst_out_valid", 32'(out_valid[0]), 32'd0);
        check("rst_s", 32'(s[0]), 32'd0);
        check("rst_cout", 32'(cout[0]), 32'd0);
        check("rst_ovf", 32'(ovf[0]), 32'd0);

        run_op(0, 16'h007A, 16'h009A, 1'b0, 1'b0, rs, rc, ro, lat);
        check("add_s", 32'(rs), 32'h0114);
        check("add_cout", 32'(rc), 32'd0);
        check("add_ovf", 32'(ro), 32'd0);
        check("add_lat", 32'(lat), 32'd4);

        run_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        check("wrap_s", 32'(rs), 32'h0000);
        check("wrap_cout", 32'(rc), 32'd1);
        check("wrap_ovf", 32'(ro), 32'd0);

        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        check("povf_s", 32'(rs), 32'h8000);
        check("povf_cout", 32'(rc), 32'd0);
        check("povf_ovf", 32'(ro), 32'd1);

        run_op(0, 16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
        check("sub_s", 32'(rs), 32'hFFFE);
        check("sub_cout", 32'(rc), 32'd0);
        check("sub_ovf", 32'(ro), 32'd0);

        run_op(0, 16'h0010, 16'h0001, 1'b1, 1'b1, rs, rc, ro, lat);
        check("subb_s", 32'(rs), 32'h000E);
        check("subb_cout", 32'(rc), 32'd1);

        // Backpressure: new operands offered throughout DONE must be ignored.
        start_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_done(0, lat);
        check("bp_lat", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            in_valid[0] = 1'b1;
            x[0]        = 16'hABC0 + 16'(i);
            @(negedge clk);
            check("bp_s", 32'(s[0]), 32'h5555);
            check("bp_valid", 32'(out_valid[0]), 32'd1);
            check("bp_ready", 32'(in_ready[0]), 32'd0);
        end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b0;
        check("bp_ready_after", 32'(in_ready[0]), 32'd1);
        check("bp_valid_after", 32'(out_valid[0]), 32'd0);
        check("bp_s_retained", 32'(s[0]), 32'h5555);
        repeat (3) @(negedge clk);
        check("idle_s_held", 32'(s[0]), 32'h5555);
        check("idle_cout_held", 32'(cout[0]), 32'd0);

        // Reset after the second slice has been written.
        start_op(0, 16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mrst_in_ready", 32'(in_ready[0]), 32'd1);
        check("mrst_valid", 32'(out_valid[0]), 32'd0);
        check("mrst_s", 32'(s[0]), 32'd0);
        check("mrst_cout", 32'(cout[0]), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid[0]) seen = 1'b1;
        end
        check("mrst_never_valid", 32'(seen), 32'd0);

        // Parameter sweep across DIGIT = 4, 1, 16.
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 6; n++) begin
                case (n)
                    0: begin ta = 16'hFFFF; tb = 16'hFFFF; tc = 1'b1; tsb = 1'b0; end
                    1: begin ta = 16'h8000; tb = 16'h0001; tc = 1'b0; tsb = 1'b1; end
                    2: begin ta = 16'h0000; tb = 16'h0000; tc = 1'b1; tsb = 1'b1; end
                    default: begin
                        ta  = 16'($urandom);
                        tb  = 16'($urandom);
                        tc  = 1'($urandom);
                        tsb = 1'($urandom);
                    end
                endcase
                ref_model(ta, tb, tc, tsb, es, ec, eo);
                run_op(k, ta, tb, tc, tsb, rs, rc, ro, lat);
                check($sformatf("sw%0d_%0d_s", k, n), 32'(rs), 32'(es));
                check($sformatf("sw%0d_%0d_cout", k, n), 32'(rc), 32'(ec));
                check($sformatf("sw%0d_%0d_ovf", k, n), 32'(ro), 32'(eo));
                check($sformatf("sw%0d_%0d_lat", k, n), 32'(lat),
                      32'(ndig[k]));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
